// File: rtl/alu_pkg.sv
// Shared definitions for the MiniAlu execute unit: opcode constants and the
// execute-unit state encoding.
package alu_pkg;

    // Opcodes carried on iOperation
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_SMUL = 4'h4;

    // Execute-unit control states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DONE    = 2'd2
    } exec_state_t;

endpackage

// File: rtl/alu_mul_exec_if.sv
// Request/response bundle between operand fetch, the execute unit and
// RAM write-back.
//
// Handshake: a request transfers on a rising edge where iValid && oReady.
// The requester keeps iValid (and its payload) up until that edge; requests
// presented while oReady=0 are ignored. oValid is a single-cycle pulse with no
// backpressure: write-back must take oResult0/1 in that very cycle, using
// oWriteEnable0/1 and oError, all of which are meaningful only while oValid=1.
interface alu_mul_exec_if #(
    parameter int WIDTH = 16
);
    logic             iValid;
    logic             oReady;
    logic [3:0]       iOperation;
    logic [WIDTH-1:0] iDataA;
    logic [WIDTH-1:0] iDataB;
    logic             oValid;
    logic [WIDTH-1:0] oResult0;
    logic [WIDTH-1:0] oResult1;
    logic             oWriteEnable0;
    logic             oWriteEnable1;
    logic             oError;

    modport master (
        output iValid, iOperation, iDataA, iDataB,
        input  oReady, oValid, oResult0, oResult1,
               oWriteEnable0, oWriteEnable1, oError
    );

    modport slave (
        input  iValid, iOperation, iDataA, iDataB,
        output oReady, oValid, oResult0, oResult1,
               oWriteEnable0, oWriteEnable1, oError
    );
endinterface

// File: rtl/alu_mul_exec_shift_add_mult.sv
// Unsigned iterative shift-add multiplier, one multiplier bit per cycle.
// 'done' is asserted in the cycle of the final iteration and 'product' then
// carries the value the accumulator takes on that edge, so the parent can
// register the finished product together with its own state change.
// Optional: ALU_MUL_EXEC_EARLY_TERM_EN finishes as soon as the remaining
// multiplier bits are all zero, applying the outstanding shifts at once.
module shift_add_mult #(
    parameter int WIDTH = 16,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    logic               busy;
    logic [CNTW-1:0]    cnt;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplr;
    logic [2*WIDTH:0]   acc_add;
    logic [2*WIDTH-1:0] acc_fin;

    // One iteration: conditional add into the upper half, then shift right
    always_comb begin
        acc_add = acc + (mplr[0] ? {1'b0, mcand, {WIDTH{1'b0}}} : {(2*WIDTH+1){1'b0}});
`ifdef ALU_MUL_EXEC_EARLY_TERM_EN
        if (mplr[WIDTH-1:1] == '0) begin
            acc_fin = (2*WIDTH)'(acc_add >> cnt);
            done    = busy;
        end else begin
            acc_fin = acc_add[2*WIDTH:1];
            done    = busy && (cnt == CNTW'(1));
        end
`else
        acc_fin = acc_add[2*WIDTH:1];
        done    = busy && (cnt == CNTW'(1));
`endif
        product = acc_fin;
    end

    // Operand capture on start, then one iteration per cycle until done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= CNTW'(WIDTH);
            acc   <= '0;
            mcand <= a;
            mplr  <= b;
        end else if (busy) begin
            acc  <= {1'b0, acc_fin};
            mplr <= mplr >> 1;
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt - CNTW'(1);
            end
        end
    end
endmodule

// File: rtl/alu_mul_exec.sv
// MiniAlu execute unit: registered ADD/SUB (one per cycle), iterative
// MUL/SMUL producing a 2*WIDTH product split over two write ports, and an
// error response for any other opcode. All outputs are flops; oReady is a
// registered copy of "next state is IDLE" so it stays low during reset.
// Optional: ALU_MUL_EXEC_EARLY_TERM_EN (shortens multiplies, see core).
module alu_mul_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    alu_mul_exec_if.slave        bus,
    output exec_state_t          dbg_state
);
    exec_state_t        state, state_next;
    logic               sign, sign_next;
    logic               ready, ready_next;
    logic               valid, valid_next;
    logic               we0, we0_next;
    logic               we1, we1_next;
    logic               err, err_next;
    logic [WIDTH-1:0]   res0, res0_next;
    logic [WIDTH-1:0]   res1, res1_next;
    logic               accept;
    logic               core_start;
    logic [WIDTH-1:0]   core_a, core_b;
    logic               core_done;
    logic [2*WIDTH-1:0] core_product;
    logic [2*WIDTH-1:0] signed_product;
    logic [WIDTH-1:0]   abs_a, abs_b;

    assign accept = bus.iValid && ready;
    assign abs_a  = bus.iDataA[WIDTH-1] ? -bus.iDataA : bus.iDataA;
    assign abs_b  = bus.iDataB[WIDTH-1] ? -bus.iDataB : bus.iDataB;
    assign signed_product = sign ? -core_product : core_product;

    shift_add_mult #(.WIDTH(WIDTH), .CNTW(CNTW)) u_mult (
        .clk     (Clock),
        .rst_n   (Reset),
        .start   (core_start),
        .a       (core_a),
        .b       (core_b),
        .done    (core_done),
        .product (core_product)
    );

    // Next-state and next-output decode
    always_comb begin
        state_next = state;
        sign_next  = sign;
        valid_next = 1'b0;
        we0_next   = 1'b0;
        we1_next   = 1'b0;
        err_next   = 1'b0;
        res0_next  = '0;
        res1_next  = '0;
        core_start = 1'b0;
        core_a     = bus.iDataA;
        core_b     = bus.iDataB;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.iOperation)
                        OP_ADD: begin
                            valid_next = 1'b1;
                            we0_next   = 1'b1;
                            res0_next  = bus.iDataA + bus.iDataB;
                        end
                        OP_SUB: begin
                            valid_next = 1'b1;
                            we0_next   = 1'b1;
                            res0_next  = bus.iDataA - bus.iDataB;
                        end
                        OP_MUL: begin
                            core_start = 1'b1;
                            sign_next  = 1'b0;
                            state_next = MUL_RUN;
                        end
                        OP_SMUL: begin
                            core_start = 1'b1;
                            core_a     = abs_a;
                            core_b     = abs_b;
                            sign_next  = bus.iDataA[WIDTH-1] ^ bus.iDataB[WIDTH-1];
                            state_next = MUL_RUN;
                        end
                        default: begin
                            valid_next = 1'b1;
                            err_next   = 1'b1;
                        end
                    endcase
                end
            end
            MUL_RUN: begin
                if (core_done) begin
                    state_next             = DONE;
                    valid_next             = 1'b1;
                    we0_next               = 1'b1;
                    we1_next               = 1'b1;
                    {res1_next, res0_next} = signed_product;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        ready_next = (state_next == IDLE);
    end

    // State and output registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            sign  <= 1'b0;
            ready <= 1'b0;
            valid <= 1'b0;
            we0   <= 1'b0;
            we1   <= 1'b0;
            err   <= 1'b0;
            res0  <= '0;
            res1  <= '0;
        end else begin
            state <= state_next;
            sign  <= sign_next;
            ready <= ready_next;
            valid <= valid_next;
            we0   <= we0_next;
            we1   <= we1_next;
            err   <= err_next;
            res0  <= res0_next;
            res1  <= res1_next;
        end
    end

    assign bus.oReady        = ready;
    assign bus.oValid        = valid;
    assign bus.oResult0      = res0;
    assign bus.oResult1      = res1;
    assign bus.oWriteEnable0 = we0;
    assign bus.oWriteEnable1 = we1;
    assign bus.oError        = err;
    assign dbg_state         = state;
endmodule

// File: tb/tb_alu_mul_exec.sv
// Testbench for alu_mul_exec: directed sequence with a scoreboard of expected
// write-back bundles and their arrival cycles.
module tb_alu_mul_exec;
  import alu_pkg::*;

  localparam int W  = 16;
  localparam int RW = 2 * W + 3;

  logic        Clock;
  logic        Reset;
  exec_state_t dbg_state;
  int          cyc;
  int          checks;
  int          errors;

  logic [RW-1:0] exp_q[$];
  int            cyc_q[$];

  alu_mul_exec_if #(.WIDTH(W)) bus ();

  alu_mul_exec #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // reference model: {error, we1, we0, result1, result0}
  function automatic logic [RW-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb, p;
    logic [W-1:0]   s;
    case (op)
      OP_ADD: begin
        s = a + b;
        return {3'b001, {W{1'b0}}, s};
      end
      OP_SUB: begin
        s = a - b;
        return {3'b001, {W{1'b0}}, s};
      end
      OP_MUL: begin
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        p  = ea * eb;
        return {3'b011, p};
      end
      OP_SMUL: begin
        ea = {{W{a[W-1]}}, a};
        eb = {{W{b[W-1]}}, b};
        p  = ea * eb;
        return {3'b011, p};
      end
      default: return {3'b100, {(2*W){1'b0}}};
    endcase
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [W-1:0] b);
    logic [W-1:0] m;
    int msb;
    if (op != OP_MUL && op != OP_SMUL) return 1;
    m = (op == OP_SMUL && b[W-1]) ? -b : b;
    msb = -1;
    for (int i = 0; i < W; i++) if (m[i]) msb = i;
`ifdef ALU_MUL_EXEC_EARLY_TERM_EN
    return (msb < 0) ? 2 : msb + 2;
`else
    return W + 1;
`endif
  endfunction

  // scoreboard: every oValid pulse must match the head of the queue
  always @(negedge Clock) begin
    if (Reset === 1'b1 && bus.oValid === 1'b1) begin
      logic [RW-1:0] obs, e;
      int c;
      obs = {bus.oError, bus.oWriteEnable1, bus.oWriteEnable0, bus.oResult1, bus.oResult0};
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_valid obs=%h exp=none", obs);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        checks++;
        assert (obs === e) else begin
          errors++;
          $error("FAIL result obs=%h exp=%h", obs, e);
        end
        checks++;
        assert (cyc == c) else begin
          errors++;
          $error("FAIL latency obs_cycle=%0d exp_cycle=%0d", cyc, c);
        end
      end
    end
  end

  // driver: present one request for one cycle, optionally scoreboard it
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    checks++;
    assert (bus.oReady === 1'b1) else begin
      errors++;
      $error("FAIL ready_at_issue obs=%b exp=1", bus.oReady);
    end
    bus.iValid     = 1'b1;
    bus.iOperation = op;
    bus.iDataA     = a;
    bus.iDataB     = b;
    if (track) begin
      exp_q.push_back(model(op, a, b));
      cyc_q.push_back(cyc + latency(op, b));
    end
    @(negedge Clock);
    bus.iValid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge Clock);
    @(negedge Clock);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout obs=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp_v);
    end
  endtask

  // directed sequence
  initial begin
    logic [3:0] op;
    cyc            = 0;
    checks         = 0;
    errors         = 0;
    Reset          = 1'b0;
    bus.iValid     = 1'b0;
    bus.iOperation = OP_NOP;
    bus.iDataA     = '0;
    bus.iDataB     = '0;

    // reset values
    repeat (3) @(negedge Clock);
    check_bit("rst_ready", bus.oReady, 1'b0);
    check_bit("rst_valid", bus.oValid, 1'b0);
    check_bit("rst_we0", bus.oWriteEnable0, 1'b0);
    check_bit("rst_we1", bus.oWriteEnable1, 1'b0);
    check_bit("rst_err", bus.oError, 1'b0);
    checks++;
    assert ({bus.oResult1, bus.oResult0} === 32'h0) else begin
      errors++;
      $error("FAIL rst_results obs=%h exp=0", {bus.oResult1, bus.oResult0});
    end
    Reset = 1'b1;
    #1 check_bit("ready_before_first_clk", bus.oReady, 1'b0);
    @(negedge Clock);
    check_bit("ready_after_release", bus.oReady, 1'b1);

    // ADD, then back-to-back SUB / ADD wrap-around
    issue(OP_ADD, 16'h0003, 16'h0004, 1'b1);
    wait_idle();
    issue(OP_SUB, 16'h0000, 16'h0001, 1'b1);
    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b1);
    check_bit("ready_after_b2b", bus.oReady, 1'b1);
    wait_idle();

    // unsigned multiply at full scale, with oReady low throughout
    issue(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b1);
    for (int i = 1; i <= 17; i++) begin
      check_bit("ready_low_in_mul", bus.oReady, 1'b0);
      @(negedge Clock);
    end
    check_bit("ready_after_mul", bus.oReady, 1'b1);
    wait_idle();

    // signed multiplies including the most-negative operand
    issue(OP_SMUL, 16'hFFFD, 16'h0005, 1'b1);
    wait_idle();
    issue(OP_SMUL, 16'h8000, 16'h8000, 1'b1);
    wait_idle();
    issue(OP_SMUL, 16'h0007, 16'hFFFE, 1'b1);
    wait_idle();
    issue(OP_MUL, 16'h0000, 16'h0000, 1'b1);
    wait_idle();
    issue(OP_MUL, 16'h1234, 16'h0003, 1'b1);
    wait_idle();

    // illegal opcodes
    issue(4'hF, 16'h1111, 16'h2222, 1'b1);
    issue(OP_NOP, 16'h0001, 16'h0001, 1'b1);
    issue(4'h5, 16'hAAAA, 16'h5555, 1'b1);
    wait_idle();

    // mid-run request ignored, then reset aborts the multiply
    issue(OP_MUL, 16'h1234, 16'h5678, 1'b0);
    bus.iValid     = 1'b1;
    bus.iOperation = OP_ADD;
    bus.iDataA     = 16'h0101;
    bus.iDataB     = 16'h0202;
    repeat (3) @(negedge Clock);
    bus.iValid = 1'b0;
    repeat (4) @(negedge Clock);
    Reset = 1'b0;
    #1 check_bit("abort_valid", bus.oValid, 1'b0);
    check_bit("abort_ready", bus.oReady, 1'b0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check_bit("abort_ready_release", bus.oReady, 1'b1);
    checks++;
    assert (dbg_state === IDLE) else begin
      errors++;
      $error("FAIL abort_state obs=%0d exp=%0d", dbg_state, IDLE);
    end
    repeat (25) @(negedge Clock);

    // random mix
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 4))
        0: op = OP_ADD;
        1: op = OP_SUB;
        2: op = OP_MUL;
        3: op = OP_SMUL;
        default: op = 4'($urandom_range(5, 15));
      endcase
      issue(op, W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)), 1'b1);
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
